// File: rtl/sc_nve_pkg.sv
// Shared definitions for the vehicle-lane consumer of the level state machine:
// velocity codes, default shift dividers and the lane width.
package sc_nve_pkg;

  localparam int LANE_W          = 8;
  localparam int DIV_SLOW_DEF    = 25000000;
  localparam int DIV_MED_DEF     = 12500000;
  localparam int DIV_FAST_DEF    = 6250000;
  localparam int PRESCALER_W_DEF = 25;

  typedef enum logic [1:0] {
    VEL_STOP = 2'b00,
    VEL_SLOW = 2'b01,
    VEL_MED  = 2'b10,
    VEL_FAST = 2'b11
  } vel_code_e;

endpackage

// File: rtl/sc_lane_prescaler_nve.sv
// Shift-rate prescaler for one road lane. Picks the divider from the velocity
// code, gates counting on the paired speed-enable line, restarts the count
// whenever the code changes and emits a one-cycle rotate enable that is
// asserted in the cycle whose rising edge performs the rotation.
module sc_lane_prescaler_nve
  import sc_nve_pkg::*;
#(
  parameter int DIV_SLOW        = DIV_SLOW_DEF,
  parameter int DIV_MED         = DIV_MED_DEF,
  parameter int DIV_FAST        = DIV_FAST_DEF,
  parameter int PRESCALER_WIDTH = PRESCALER_W_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       pause,
  input  logic [1:0] vel_code,
  input  logic       hab_fast,
  input  logic       hab_med,
  input  logic       hab_slow,
  output logic       rotate_en
);

  localparam logic [PRESCALER_WIDTH-1:0] SLOW_LAST = PRESCALER_WIDTH'(DIV_SLOW - 1);
  localparam logic [PRESCALER_WIDTH-1:0] MED_LAST  = PRESCALER_WIDTH'(DIV_MED - 1);
  localparam logic [PRESCALER_WIDTH-1:0] FAST_LAST = PRESCALER_WIDTH'(DIV_FAST - 1);

  vel_code_e                  code_in;
  vel_code_e                  code_p1;
  logic [PRESCALER_WIDTH-1:0] count_p1;
  logic [PRESCALER_WIDTH-1:0] last;
  logic                       run;
  logic                       changed;

  assign code_in = vel_code_e'(vel_code);
  assign changed = (code_in != code_p1);

  // Terminal count and paired speed enable for the incoming velocity code
  always_comb begin
    last = '0;
    run  = 1'b0;
    case (code_in)
      VEL_SLOW: begin last = SLOW_LAST; run = hab_slow; end
      VEL_MED:  begin last = MED_LAST;  run = hab_med;  end
      VEL_FAST: begin last = FAST_LAST; run = hab_fast; end
      default:  begin last = '0;        run = 1'b0;     end
    endcase
  end

  // A code change swallows the edge: no rotation while the count restarts
  assign rotate_en = !load && !pause && !changed && run && (count_p1 == last);

  // Prescaler count and stored velocity code; pause freezes both in shift mode
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_p1 <= '0;
      code_p1  <= VEL_STOP;
    end else if (load) begin
      count_p1 <= '0;
      code_p1  <= code_in;
    end else if (!pause) begin
      code_p1 <= code_in;
      if (changed)
        count_p1 <= '0;
      else if (run)
        count_p1 <= (count_p1 == last) ? '0 : count_p1 + 1'b1;
    end
  end

endmodule

// File: rtl/sc_lane_shift_nve.sv
// One road lane of the frogger LED matrix: holds an 8-bit lane pattern,
// loads it from the level state machine, rotates it at the selected speed and
// flags overlap with the frog column one cycle later.
// Optional build macro SC_LANE_SHIFT_NVE_PAUSE_EN adds SC_LANE_SHIFT_NVE_PAUSE_IN,
// which freezes the lane, prescaler and stored velocity code in shift mode.
module sc_lane_shift_nve
  import sc_nve_pkg::*;
#(
  parameter int DATAWIDTH_BUS   = LANE_W,
  parameter int DIV_SLOW        = DIV_SLOW_DEF,
  parameter int DIV_MED         = DIV_MED_DEF,
  parameter int DIV_FAST        = DIV_FAST_DEF,
  parameter int PRESCALER_WIDTH = PRESCALER_W_DEF,
  parameter int SHIFT_DIR       = 0
) (
  input  logic                     SC_LANE_SHIFT_NVE_CLOCK_50,
  input  logic                     SC_LANE_SHIFT_NVE_RESET,
`ifdef SC_LANE_SHIFT_NVE_PAUSE_EN
  input  logic                     SC_LANE_SHIFT_NVE_PAUSE_IN,
`endif
  input  logic                     SC_LANE_SHIFT_NVE_LOAD_SHIFT_IN,
  input  logic [DATAWIDTH_BUS-1:0] SC_LANE_SHIFT_NVE_REGNIVEL_IN,
  input  logic [1:0]               SC_LANE_SHIFT_NVE_VEL_SELECT_IN,
  input  logic                     SC_LANE_SHIFT_NVE_HAB_VEL0_IN,
  input  logic                     SC_LANE_SHIFT_NVE_HAB_VEL1_IN,
  input  logic                     SC_LANE_SHIFT_NVE_HAB_VEL2_IN,
  input  logic [DATAWIDTH_BUS-1:0] SC_LANE_SHIFT_NVE_FROG_POS_IN,
  output logic [DATAWIDTH_BUS-1:0] SC_LANE_SHIFT_NVE_LANE_OUT,
  output logic                     SC_LANE_SHIFT_NVE_TICK_OUT,
  output logic                     SC_LANE_SHIFT_NVE_COLLISION_OUT
);

  // Rotate by one position; SHIFT_DIR 0 wraps the MSB into bit 0
  function automatic logic [DATAWIDTH_BUS-1:0] rotate_one(input logic [DATAWIDTH_BUS-1:0] lane);
    if (SHIFT_DIR == 0)
      return {lane[DATAWIDTH_BUS-2:0], lane[DATAWIDTH_BUS-1]};
    else
      return {lane[0], lane[DATAWIDTH_BUS-1:1]};
  endfunction

  logic                     clk;
  logic                     rst_n;
  logic                     load;
  logic                     pause;
  logic [DATAWIDTH_BUS-1:0] pattern;
  logic [DATAWIDTH_BUS-1:0] frog;
  logic                     rotate_en;
  logic [DATAWIDTH_BUS-1:0] lane_p1;
  logic                     tick_p1;
  logic                     coll_p1;

  assign clk     = SC_LANE_SHIFT_NVE_CLOCK_50;
  assign rst_n   = SC_LANE_SHIFT_NVE_RESET;
  assign load    = SC_LANE_SHIFT_NVE_LOAD_SHIFT_IN;
  assign pattern = SC_LANE_SHIFT_NVE_REGNIVEL_IN;
  assign frog    = SC_LANE_SHIFT_NVE_FROG_POS_IN;

`ifdef SC_LANE_SHIFT_NVE_PAUSE_EN
  assign pause = SC_LANE_SHIFT_NVE_PAUSE_IN;
`else
  assign pause = 1'b0;
`endif

  sc_lane_prescaler_nve #(
    .DIV_SLOW        (DIV_SLOW),
    .DIV_MED         (DIV_MED),
    .DIV_FAST        (DIV_FAST),
    .PRESCALER_WIDTH (PRESCALER_WIDTH)
  ) u_prescaler (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .pause     (pause),
    .vel_code  (SC_LANE_SHIFT_NVE_VEL_SELECT_IN),
    .hab_fast  (SC_LANE_SHIFT_NVE_HAB_VEL0_IN),
    .hab_med   (SC_LANE_SHIFT_NVE_HAB_VEL1_IN),
    .hab_slow  (SC_LANE_SHIFT_NVE_HAB_VEL2_IN),
    .rotate_en (rotate_en)
  );

  // Lane register: zero patterns are wait states and never blank the lane
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lane_p1 <= '0;
      tick_p1 <= 1'b0;
    end else begin
      tick_p1 <= rotate_en;
      if (load && (pattern != '0))
        lane_p1 <= pattern;
      else if (rotate_en)
        lane_p1 <= rotate_one(lane_p1);
    end
  end

  // Collision flag from the lane as it stood before this edge
  always_ff @(posedge clk) begin
    if (!rst_n)
      coll_p1 <= 1'b0;
    else
      coll_p1 <= |(lane_p1 & frog);
  end

  assign SC_LANE_SHIFT_NVE_LANE_OUT      = lane_p1;
  assign SC_LANE_SHIFT_NVE_TICK_OUT      = tick_p1;
  assign SC_LANE_SHIFT_NVE_COLLISION_OUT = coll_p1;

endmodule
